// File: rtl/inpkt_config_multi_pkg.sv
// Shared pkt_comm definitions: receiver state encodings, err_code values and
// the msb() helper used to size counters and subtype registers.
package inpkt_config_multi_pkg;

  typedef enum logic [1:0] {
    ST_SUBTYPE = 2'd0,
    ST_DATA    = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SUBTYPE = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_LONG    = 2'd3;

  // Bit index of the most significant set bit of n (0 for n <= 1).
  function automatic int unsigned msb(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((n >> i) != 0) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/inpkt_config_stage.sv
// Byte-lane staging register for inpkt_config_multi: indexed byte write and
// synchronous clear; data shows the register with this cycle's write applied.
module inpkt_config_stage
  import inpkt_config_multi_pkg::*;
#(
  parameter int unsigned N_BYTES = 2,
  parameter int unsigned IDX_W   = msb(N_BYTES) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [7:0]           din,
  output logic [8*N_BYTES-1:0] data
);

  logic [8*N_BYTES-1:0] q;

  // Forwarding the pending byte lets the commit capture the final byte on the
  // same edge that samples it.
  always_comb begin
    data = q;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      if (we && idx == IDX_W'(i)) data[8*i +: 8] = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= data;
    end
  end

endmodule

// File: rtl/inpkt_config_multi.sv
// Multi-subtype configuration packet receiver: subtype byte + little-endian
// payload, committed atomically per subtype. Optional INPKT_CONFIG_ERR_CLEAR_EN.
module inpkt_config_multi
  import inpkt_config_multi_pkg::*;
#(
  parameter int unsigned N_SUBTYPES = 2,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [7:0]                       din,
  input  logic                             wr_en,
  input  logic                             pkt_end,
`ifdef INPKT_CONFIG_ERR_CLEAR_EN
  input  logic                             err_clr,
`endif
  output logic                             full,
  output logic [N_SUBTYPES*DATA_WIDTH-1:0] dout,
  output logic [N_SUBTYPES-1:0]            upd,
  output logic                             err,
  output logic [1:0]                       err_code
);

  localparam int unsigned N_BYTES = (DATA_WIDTH + 7) / 8;
  localparam int unsigned CW      = msb(N_BYTES) + 1;
  localparam int unsigned SW      = msb(N_SUBTYPES) + 1;

  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [SW-1:0]        sub, sub_next;
  logic [1:0]           code_next;
  logic                 err_q;
  logic                 commit, stage_clr, stage_we;
  logic                 sub_ok, last;
  logic [8*N_BYTES-1:0] stage_data;

  inpkt_config_stage #(
    .N_BYTES (N_BYTES),
    .IDX_W   (CW)
  ) u_stage (
    .clk  (CLK),
    .rst  (RST),
    .clr  (stage_clr),
    .we   (stage_we),
    .idx  (cnt),
    .din  (din),
    .data (stage_data)
  );

  assign sub_ok = (din != 8'd0) && (din <= 8'(N_SUBTYPES));
  assign last   = (cnt == CW'(N_BYTES - 1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sub_next   = sub;
    code_next  = err_code;
    commit     = 1'b0;
    stage_clr  = 1'b0;
    stage_we   = 1'b0;
    case (state)
      ST_SUBTYPE: begin
        if (wr_en) begin
          if (!sub_ok) begin
            state_next = ST_ERROR;
            code_next  = ERR_SUBTYPE;
          end else if (pkt_end) begin
            state_next = ST_ERROR;
            code_next  = ERR_SHORT;
          end else begin
            sub_next   = din[SW-1:0];
            cnt_next   = '0;
            stage_clr  = 1'b1;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (wr_en) begin
          stage_we = 1'b1;
          cnt_next = cnt + 1'b1;
          if (pkt_end && last) begin
            commit     = 1'b1;
            state_next = ST_SUBTYPE;
          end else if (pkt_end) begin
            state_next = ST_ERROR;
            code_next  = ERR_SHORT;
          end else if (last) begin
            state_next = ST_ERROR;
            code_next  = ERR_LONG;
          end
        end
      end
      ST_ERROR: begin
`ifdef INPKT_CONFIG_ERR_CLEAR_EN
        if (err_clr) begin
          state_next = ST_SUBTYPE;
          code_next  = ERR_NONE;
        end
`endif
      end
      default: state_next = ST_SUBTYPE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_SUBTYPE;
      cnt      <= '0;
      sub      <= '0;
      err_code <= ERR_NONE;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sub      <= sub_next;
      err_code <= code_next;
      err_q    <= (state_next == ST_ERROR);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout <= '0;
      upd  <= '0;
    end else begin
      upd <= '0;
      for (int unsigned k = 0; k < N_SUBTYPES; k++) begin
        if (commit && sub == SW'(k + 1)) begin
          dout[DATA_WIDTH*k +: DATA_WIDTH] <= stage_data[DATA_WIDTH-1:0];
          upd[k]                           <= 1'b1;
        end
      end
    end
  end

  assign full = err_q;
  assign err  = err_q;

endmodule

// File: tb/tb_inpkt_config_multi.sv
// Scoreboard bench for inpkt_config_multi: one byte stream drives a 16-bit and
// a 12-bit instance; a negedge monitor checks every commit/error event.
module tb_inpkt_config_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        wr_en;
  logic        pkt_end;
`ifdef INPKT_CONFIG_ERR_CLEAR_EN
  logic        err_clr;
`endif

  logic        full_a, err_a, full_b, err_b;
  logic [31:0] dout_a;
  logic [23:0] dout_b;
  logic [1:0]  upd_a, upd_b, code_a, code_b;

  always #5 clk = ~clk;

  inpkt_config_multi #(.N_SUBTYPES(2), .DATA_WIDTH(16)) dut_a (
    .CLK      (clk),
    .RST      (rst),
    .din      (din),
    .wr_en    (wr_en),
    .pkt_end  (pkt_end),
`ifdef INPKT_CONFIG_ERR_CLEAR_EN
    .err_clr  (err_clr),
`endif
    .full     (full_a),
    .dout     (dout_a),
    .upd      (upd_a),
    .err      (err_a),
    .err_code (code_a)
  );

  inpkt_config_multi #(.N_SUBTYPES(2), .DATA_WIDTH(12)) dut_b (
    .CLK      (clk),
    .RST      (rst),
    .din      (din),
    .wr_en    (wr_en),
    .pkt_end  (pkt_end),
`ifdef INPKT_CONFIG_ERR_CLEAR_EN
    .err_clr  (err_clr),
`endif
    .full     (full_b),
    .dout     (dout_b),
    .upd      (upd_b),
    .err      (err_b),
    .err_code (code_b)
  );

  typedef struct {
    logic [1:0]  upd;
    logic [31:0] da;
    logic [23:0] db;
    logic [1:0]  code;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: an event is any upd pulse or a rising err on either instance.
  logic err_prev_a = 1'b0;
  logic err_prev_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (upd_a != 2'b00 || upd_b != 2'b00 || (err_a && !err_prev_a) || (err_b && !err_prev_b)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual upd_a=%0h upd_b=%0h err_a=%0b err_b=%0b required none",
                 upd_a, upd_b, err_a, err_b);
      end else begin
        e = q.pop_front();
        chk("upd_a", 64'(upd_a), 64'(e.upd));
        chk("upd_b", 64'(upd_b), 64'(e.upd));
        chk("dout_a", 64'(dout_a), 64'(e.da));
        chk("dout_b", 64'(dout_b), 64'(e.db));
        chk("err_code_a", 64'(code_a), 64'(e.code));
        chk("err_code_b", 64'(code_b), 64'(e.code));
        chk("err_a", 64'(err_a), 64'(e.code != 2'd0));
        chk("full_a", 64'(full_a), 64'(e.code != 2'd0));
        chk("full_b", 64'(full_b), 64'(e.code != 2'd0));
      end
    end
    err_prev_a = err_a;
    err_prev_b = err_b;
  end

  task automatic expect_ev(input logic [1:0] u, input logic [31:0] da, input logic [23:0] db,
                           input logic [1:0] code);
    exp_t e;
    e.upd = u; e.da = da; e.db = db; e.code = code;
    q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d, input logic e);
    din = d; wr_en = 1'b1; pkt_end = e;
    @(posedge clk);
    #1;
    wr_en = 1'b0; pkt_end = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    #1;
    chk(name, 64'(q.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dout_a"}, 64'(dout_a), 64'd0);
    chk({tag, "_dout_b"}, 64'(dout_b), 64'd0);
    chk({tag, "_upd_a"}, 64'(upd_a), 64'd0);
    chk({tag, "_full_a"}, 64'(full_a), 64'd0);
    chk({tag, "_err_a"}, 64'(err_a), 64'd0);
    chk({tag, "_code_a"}, 64'(code_a), 64'd0);
    chk({tag, "_full_b"}, 64'(full_b), 64'd0);
    chk({tag, "_code_b"}, 64'(code_b), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; din = 8'h00; wr_en = 1'b0; pkt_end = 1'b0;
`ifdef INPKT_CONFIG_ERR_CLEAR_EN
    err_clr = 1'b0;
`endif
    #2;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic commit, subtype 1.
    expect_ev(2'b01, 32'h0000_1234, 24'h000_234, 2'd0);
    wr(8'h01, 1'b0); wr(8'h34, 1'b0); wr(8'h12, 1'b1);
    drain("drain_basic");

    // Back-to-back packets, no gap.
    expect_ev(2'b10, 32'hABCD_1234, 24'hBCD_234, 2'd0);
    expect_ev(2'b01, 32'hABCD_0001, 24'hBCD_001, 2'd0);
    wr(8'h02, 1'b0); wr(8'hCD, 1'b0); wr(8'hAB, 1'b1);
    wr(8'h01, 1'b0); wr(8'h01, 1'b0); wr(8'h00, 1'b1);
    drain("drain_b2b");

    // All-ones payload: 12-bit instance discards the top nibble.
    expect_ev(2'b01, 32'hABCD_FFFF, 24'hBCD_FFF, 2'd0);
    wr(8'h01, 1'b0); wr(8'hFF, 1'b0); wr(8'hFF, 1'b1);
    drain("drain_ones");

    // Asynchronous reset mid-packet aborts without commit.
    wr(8'h02, 1'b0); wr(8'h77, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_after_dout_a", 64'(dout_a), 64'd0);

    // Short packet: code 2, dout unchanged, later writes ignored.
    expect_ev(2'b01, 32'h0000_5678, 24'h000_678, 2'd0);
    wr(8'h01, 1'b0); wr(8'h78, 1'b0); wr(8'h56, 1'b1);
    drain("drain_pre_short");
    expect_ev(2'b00, 32'h0000_5678, 24'h000_678, 2'd2);
    wr(8'h01, 1'b0); wr(8'h55, 1'b1);
    drain("drain_short");
    wr(8'h02, 1'b0); wr(8'h34, 1'b0); wr(8'h12, 1'b1);
    #2;
    chk("short_sticky_dout_a", 64'(dout_a), 64'h0000_5678);
    chk("short_sticky_full", 64'(full_a), 64'd1);
    chk("short_sticky_code", 64'(code_a), 64'd2);

    // Long packet: code 3 on the second payload byte.
    pulse_reset();
    expect_ev(2'b10, 32'h1234_0000, 24'h234_000, 2'd0);
    wr(8'h02, 1'b0); wr(8'h34, 1'b0); wr(8'h12, 1'b1);
    drain("drain_pre_long");
    expect_ev(2'b00, 32'h1234_0000, 24'h234_000, 2'd3);
    wr(8'h01, 1'b0); wr(8'h11, 1'b0); wr(8'h22, 1'b0);
    drain("drain_long");
    wr(8'h33, 1'b1);
    #2;
    chk("long_dout_a", 64'(dout_a), 64'h1234_0000);
    chk("long_code_b", 64'(code_b), 64'd3);

    // Subtype out of range, above and below.
    pulse_reset();
    expect_ev(2'b00, 32'h0, 24'h0, 2'd1);
    wr(8'h03, 1'b0);
    drain("drain_sub3");
    wr(8'h01, 1'b0); wr(8'h55, 1'b1);
    #2;
    chk("sub3_code_sticky", 64'(code_a), 64'd1);
    chk("sub3_full", 64'(full_a), 64'd1);
    pulse_reset();
    expect_ev(2'b00, 32'h0, 24'h0, 2'd1);
    wr(8'h00, 1'b0);
    drain("drain_sub0");

    // Valid subtype byte carrying pkt_end.
    pulse_reset();
    expect_ev(2'b00, 32'h0, 24'h0, 2'd2);
    wr(8'h02, 1'b1);
    drain("drain_sub_end");

`ifdef INPKT_CONFIG_ERR_CLEAR_EN
    // err_clr wins over a simultaneous write; dout keeps its value.
    pulse_reset();
    expect_ev(2'b10, 32'h1234_0000, 24'h234_000, 2'd0);
    wr(8'h02, 1'b0); wr(8'h34, 1'b0); wr(8'h12, 1'b1);
    drain("drain_pre_clr");
    expect_ev(2'b00, 32'h1234_0000, 24'h234_000, 2'd1);
    wr(8'h05, 1'b0);
    drain("drain_clr_err");
    din = 8'h01; wr_en = 1'b1; err_clr = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; err_clr = 1'b0;
    chk("clr_err", 64'(err_a), 64'd0);
    chk("clr_full", 64'(full_a), 64'd0);
    chk("clr_code", 64'(code_a), 64'd0);
    chk("clr_dout", 64'(dout_a), 64'h1234_0000);
    expect_ev(2'b01, 32'h1234_0002, 24'h234_002, 2'd0);
    wr(8'h01, 1'b0); wr(8'h02, 1'b0); wr(8'h00, 1'b1);
    drain("drain_after_clr");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
